// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control FSM (lw, sw, R/I-type ALU, jal, beq)
// Inputs : clk, reset_n (async, active-low), op[6:0], funct3[2:0], funct7b5, Zero
// Outputs: ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
//          AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ, ERROR
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FN = 2'b10;
  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch, reg_write, mem_write, illegal;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                          (op == OP_R)   ? EXECR :
                          (op == OP_I)   ? EXECI :
                          (op == OP_JAL) ? JAL   :
                          (op == OP_BEQ) ? BEQ   : ERROR;
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECR, EXECI, JAL: state_d = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BEQ: state_d = FETCH;
      ERROR:    state_d = ERROR;
      default:  state_d = FETCH;
    endcase
  end
  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_op    = ALU_ADD;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH:    begin ALUSrcB = 2'b10; ResultSrc = 2'b10; IRWrite = 1'b1; pc_update = 1'b1; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; reg_write = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; end
      EXECR:    begin ALUSrcA = 2'b10; alu_op = ALU_FN; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = ALU_FN; end
      ALUWB:    reg_write = 1'b1;
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      BEQ:      begin ALUSrcA = 2'b10; alu_op = ALU_SUB; branch = 1'b1; end
      ERROR:    illegal = 1'b1;
      default:  ;
    endcase
  end
  // Write strobes are masked by reset_n so nothing commits while reset is held,
  // even though FETCH itself requests a PC update.
  assign PCWrite  = reset_n & (pc_update | (branch & Zero));
  assign RegWrite = reset_n & reg_write;
  assign MemWrite = reset_n & mem_write;
  assign Illegal  = reset_n & illegal;
  // Subtract only for R-type (op[5]=1) with funct7b5; addi ignores funct7b5.
  assign ALUControl = (alu_op == ALU_SUB) ? 3'b001 :
                      (alu_op != ALU_FN)  ? 3'b000 :
                      (funct3 == 3'b000)  ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                      (funct3 == 3'b010)  ? 3'b101 :
                      (funct3 == 3'b110)  ? 3'b011 :
                      (funct3 == 3'b111)  ? 3'b010 : 3'b000;
  assign ImmSrc = (op == OP_SW)  ? 2'b01 :
                  (op == OP_BEQ) ? 2'b10 :
                  (op == OP_JAL) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed checks of the multicycle control FSM
module tb_mc_controller;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0, Zero = 1'b0;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
  int         total = 0, bad = 0;
  logic [14:0] outs;
  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Illegal(Illegal)
  );
  always #5 clk = ~clk;
  // {ALUSrcA, ALUSrcB, ALUControl, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal}
  assign outs = {ALUSrcA, ALUSrcB, ALUControl, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal};
  localparam logic [14:0] V_FETCH  = 15'b00_10_000_10_011000;
  localparam logic [14:0] V_RST    = 15'b00_10_000_10_010000;
  localparam logic [14:0] V_DECODE = 15'b01_01_000_00_000000;
  localparam logic [14:0] V_MEMADR = 15'b10_01_000_00_000000;
  localparam logic [14:0] V_MEMRD  = 15'b00_00_000_00_100000;
  localparam logic [14:0] V_MEMWB  = 15'b00_00_000_01_000100;
  localparam logic [14:0] V_MEMWR  = 15'b00_00_000_00_100010;
  localparam logic [14:0] V_SUBR   = 15'b10_00_001_00_000000;
  localparam logic [14:0] V_ADDI   = 15'b10_01_000_00_000000;
  localparam logic [14:0] V_ALUWB  = 15'b00_00_000_00_000100;
  localparam logic [14:0] V_JAL    = 15'b01_10_000_00_001000;
  localparam logic [14:0] V_BEQT   = 15'b10_00_001_00_001000;
  localparam logic [14:0] V_BEQN   = 15'b10_00_001_00_000000;
  localparam logic [14:0] V_ERROR  = 15'b00_00_000_00_000001;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] f3s [3] = '{3'b010, 3'b110, 3'b111};
    logic [2:0] cts [3] = '{3'b101, 3'b011, 3'b010};
    #12;
    chk("rst_hold", outs, V_RST);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("fetch0", outs, V_FETCH);
    step(); chk("lw_decode", outs, V_DECODE);
    step(); chk("lw_memadr", outs, V_MEMADR);
    step(); chk("lw_memread", outs, V_MEMRD);
    step(); chk("lw_memwb", outs, V_MEMWB);
    step(); chk("lw_fetch", outs, V_FETCH);
    op = 7'b0100011;
    step(); chk("sw_decode", outs, V_DECODE);
    chk("sw_imm", ImmSrc, 2'b01);
    step(); chk("sw_memadr", outs, V_MEMADR);
    step(); chk("sw_memwrite", outs, V_MEMWR);
    op = 7'b0000011;
    step(); chk("sw_fetch", outs, V_FETCH);
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); chk("sub_decode", outs, V_DECODE);
    step(); chk("sub_execr", outs, V_SUBR);
    step(); chk("sub_aluwb", outs, V_ALUWB);
    op = 7'b0010011;
    step(); chk("sub_fetch", outs, V_FETCH);
    step(); chk("addi_decode", outs, V_DECODE);
    step(); chk("addi_execi", outs, V_ADDI);
    step(); chk("addi_aluwb", outs, V_ALUWB);
    step();
    op = 7'b0110011; funct7b5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      funct3 = f3s[i];
      step(); step();
      chk("r_aluctl", ALUControl, cts[i]);
      step(); step();
    end
    op = 7'b1101111;
    step(); chk("jal_imm", ImmSrc, 2'b11);
    step(); chk("jal_state", outs, V_JAL);
    op = 7'b1111111;
    step(); chk("jal_aluwb", outs, V_ALUWB);
    op = 7'b1100011; Zero = 1'b1;
    step(); chk("jal_fetch", outs, V_FETCH);
    step(); chk("beq_imm", ImmSrc, 2'b10);
    step(); chk("beq_taken", outs, V_BEQT);
    Zero = 1'b0;
    #1 chk("beq_zero_comb", PCWrite, 1'b0);
    step(); chk("beq_t_fetch", outs, V_FETCH);
    step(); step(); chk("beq_not", outs, V_BEQN);
    step(); chk("beq_n_fetch", outs, V_FETCH);
    op = 7'b1111111;
    step(); chk("ill_decode", outs, V_DECODE);
    for (int i = 0; i < 10; i++) begin
      step(); chk("ill_hold", outs, V_ERROR);
      op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom); Zero = 1'($urandom);
    end
    #2 reset_n = 1'b0;
    #1 chk("ill_rst", outs, V_RST);
    reset_n = 1'b1;
    #1 chk("ill_fetch", outs, V_FETCH);
    op = 7'b0000011; Zero = 1'b0;
    step(); step(); step();
    chk("mr_memread", outs, V_MEMRD);
    #3 reset_n = 1'b0;
    #1 chk("mr_rst", outs, V_RST);
    chk("mr_regmem", {RegWrite, MemWrite}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("mr_fetch", outs, V_FETCH);
    step(); chk("mr_decode", outs, V_DECODE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
